// File: rtl/gene_match_pkg.sv
// Shared encodings for the gene-matcher control slice: opcodes, base codes,
// controller FSM states and the legal pattern-length window.
package gene_match_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SCAN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_CLR   = 2'd3
  } state_t;

endpackage

// File: rtl/gene_match_satcnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module gene_match_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gene_match_ctrl.sv
// Command FSM and hit bookkeeping for the gene matcher: loads the pattern,
// streams scan bases to the core and counts hits once the window is full.
module gene_match_ctrl
  import gene_match_pkg::*;
#(
  parameter int PAT_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int POS_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_base,
  output logic                       cmd_ready,
  output logic                       core_clr,
  output logic                       core_pat_we,
  output logic [$clog2(PAT_LEN)-1:0] core_pat_idx,
  output logic                       core_shift,
  output logic [1:0]                 core_base,
  input  logic                       core_hit,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [POS_W-1:0]           first_pos,
  output logic                       found,
  output logic                       armed,
  output logic                       err
);

  localparam int                 IDX_W    = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(PAT_LEN - 1);
  localparam logic [POS_W-1:0]   POS_FULL = POS_W'(PAT_LEN - 1);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("gene_match_ctrl: PAT_LEN outside 2..16");
  end

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_clr;
  logic               r_pat_we;
  logic [IDX_W-1:0]   r_pat_idx;
  logic               r_shift;
  logic [1:0]         r_base;
  logic               r_full_p0;
  logic [POS_W-1:0]   r_pos_p0;
  logic               r_vld_p1;
  logic [POS_W-1:0]   r_pos_p1;
  logic [POS_W-1:0]   r_first_pos;
  logic               r_found;
  logic               r_armed;
  logic               r_err;

  logic               w_in_clr;
  logic               w_accept;
  logic               w_scan_go;
  logic               w_hit_cnt;
  logic [POS_W-1:0]   w_scan_pos;
  logic [CNT_W-1:0]   w_match_cnt;

  assign w_in_clr  = (r_state == ST_CLR);
  assign cmd_ready = rst_n & ena & ~w_in_clr;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_scan_go = w_accept & (cmd_op == OP_SCAN) & (r_state == ST_ARMED);
  // A hit whose shift is still in flight when CLR runs is dropped here.
  assign w_hit_cnt = r_vld_p1 & core_hit & ~w_in_clr;

  gene_match_satcnt #(.W(POS_W)) u_scan_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_in_clr),
    .i_inc (w_scan_go),
    .o_q   (w_scan_pos)
  );

  gene_match_satcnt #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_in_clr),
    .i_inc (w_hit_cnt),
    .o_q   (w_match_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_clr       <= 1'b0;
      r_pat_we    <= 1'b0;
      r_pat_idx   <= '0;
      r_shift     <= 1'b0;
      r_base      <= '0;
      r_full_p0   <= 1'b0;
      r_pos_p0    <= '0;
      r_vld_p1    <= 1'b0;
      r_pos_p1    <= '0;
      r_first_pos <= '0;
      r_found     <= 1'b0;
      r_armed     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_clr     <= 1'b0;
      r_pat_we  <= 1'b0;
      r_pat_idx <= '0;
      r_shift   <= 1'b0;
      r_base    <= '0;
      // p0 -> p1: shift strobe is on the pins, core answers next cycle
      r_vld_p1  <= r_shift & r_full_p0;
      r_pos_p1  <= r_pos_p0;
      // p1: core_hit is valid now
      if (w_hit_cnt && !r_found) begin
        r_found     <= 1'b1;
        r_first_pos <= r_pos_p1;
      end
      if (w_in_clr) begin
        r_state     <= ST_IDLE;
        r_idx       <= '0;
        r_first_pos <= '0;
        r_found     <= 1'b0;
        r_armed     <= 1'b0;
        r_err       <= 1'b0;
        r_vld_p1    <= 1'b0;
      end else if (w_accept) begin
        case (cmd_op)
          OP_LOAD: begin
            if (r_state == ST_ARMED) begin
              r_err <= 1'b1;
            end else begin
              r_pat_we  <= 1'b1;
              r_pat_idx <= r_idx;
              r_base    <= cmd_base;
              if (r_idx == IDX_LAST) begin
                r_state <= ST_ARMED;
                r_armed <= 1'b1;
                r_idx   <= '0;
              end else begin
                r_state <= ST_LOAD;
                r_idx   <= r_idx + 1'b1;
              end
            end
          end
          OP_SCAN: begin
            if (r_state != ST_ARMED) begin
              r_err <= 1'b1;
            end else begin
              // p0: tag the shift with window-full and last-base position
              r_shift   <= 1'b1;
              r_base    <= cmd_base;
              r_full_p0 <= (w_scan_pos >= POS_FULL);
              r_pos_p0  <= w_scan_pos;
            end
          end
          OP_CLEAR: begin
            r_state <= ST_CLR;
            r_clr   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign core_clr     = r_clr;
  assign core_pat_we  = r_pat_we;
  assign core_pat_idx = r_pat_idx;
  assign core_shift   = r_shift;
  assign core_base    = r_base;
  assign match_cnt    = w_match_cnt;
  assign first_pos    = r_first_pos;
  assign found        = r_found;
  assign armed        = r_armed;
  assign err          = r_err;

endmodule

// File: doc/gene_match_ctrl.md
# gene_match_ctrl

Control and scheduling block for the gene-matcher datapath inside `tt_um_gene_matcher`. It accepts host commands, writes pattern bases into the matcher core's pattern store, and streams sequence bases into the core's sliding window. It masks core hits until the window is full, then counts them and reports status back to the pin-level wrapper. The comparator core itself sits outside this block.

## Interface
- `PAT_LEN`, default 8: number of pattern bases; legal range 2..16.
- `CNT_W`, default 8: width of the match counter.
- `POS_W`, default 12: width of the scan-position counter.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  design enable. When low, no command is accepted and all state is held.
- `cmd_valid`  in  1  host command valid.
- `cmd_op`  in  2  opcode: 00 NOP, 01 LOAD, 10 SCAN, 11 CLEAR.
- `cmd_base`  in  2  base for the command: A=00, C=01, G=10, T=11.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `core_clr`  out  1  one-cycle clear pulse to the core.
- `core_pat_we`  out  1  pattern write strobe.
- `core_pat_idx`  out  $clog2(PAT_LEN)  pattern write index.
- `core_shift`  out  1  shift `core_base` into the window.
- `core_base`  out  2  base for the pattern write or the window shift.
- `core_hit`  in  1  core match flag, valid the cycle after `core_shift`.
- `match_cnt`  out  CNT_W  number of counted hits; saturates at all-ones.
- `first_pos`  out  POS_W  scan position of the first counted hit.
- `found`  out  1  at least one hit has been counted.
- `armed`  out  1  pattern is complete and scanning is allowed.
- `err`  out  1  sticky illegal-command flag.

## Operation
- Accept condition: `cmd_valid & cmd_ready`. `cmd_ready = ena & (state != CLR)`.
- The FSM states are IDLE, LOAD, ARMED and CLR. Reset enters IDLE.
- **IDLE**
  - LOAD: write the base at idx 0. If `PAT_LEN` > 1, go to LOAD with idx=1.
  - SCAN: set `err`; no other effect.
  - CLEAR: go to CLR.
- **LOAD**
  - LOAD: write the base at idx and increment idx. After writing idx `PAT_LEN-1`, go to ARMED and set `armed`.
  - SCAN: set `err`; no other effect.
- **ARMED**
  - SCAN: pulse `core_shift` with the base and increment `scan_pos`, which saturates at all-ones.
  - LOAD: set `err`; ignored. The host must CLEAR before loading a new pattern.
- **CLR**: lasts exactly one cycle with `core_clr` high. On exit it has zeroed idx, `scan_pos`, `match_cnt`, `first_pos`, `found`, `armed`, `err` and the pending-hit pipeline. The FSM returns to IDLE.
- NOP is accepted in any state and has no effect.
- Hit masking: a hit is counted only when its shift was shift number `PAT_LEN` or later, i.e. the window was full. Each shift carries a tag: `window_full` and its position.
- Counting a hit increments `match_cnt` (saturating). On the first counted hit, `first_pos` receives the 0-based position of the window's last base and `found` is set.
- CLEAR accepted while a hit is pending (shift issued, hit not yet sampled): the hit is discarded; CLEAR wins.

## Timing
- Reset values: `cmd_ready`=0 while `rst_n` is low, and 1 after reset if `ena`=1. Every other output is 0.
- All core-side outputs are registered. A command accepted at edge N drives its strobe and base during cycle N+1, for exactly one cycle.
- `core_hit` is sampled at edge N+2. `match_cnt`, `first_pos` and `found` are updated at that same edge.
- Back-to-back SCANs are allowed every cycle: throughput is 1 base per cycle, and the hit pipeline depth is 1.
- `armed` rises at the edge following acceptance of the final LOAD.
- If `ena` drops mid-stream, in-flight strobes and the pending hit still complete; no new command is accepted.
- Asynchronous reset mid-operation clears everything immediately, including any pending hit.

## Structure
- Shared package `gene_match_pkg`:
  - opcode localparams;
  - base encoding;
  - FSM state enum;
  - `PAT_LEN` bounds check constants.
- Sub-module `gene_match_satcnt`, a parameterised saturating counter with increment and clear. It is used for `match_cnt` and `scan_pos`.
- The FSM, hit pipeline and masking logic all live in `gene_match_ctrl`.

## Test plan
- **Load then scan:** PAT_LEN=4; LOAD A,C,G,T; `armed`=1 at the edge after the 4th LOAD. Then SCAN A,C,G,T with the core model asserting a hit after the 4th shift. Expect `match_cnt`=1, `first_pos`=3, `found`=1, reached 2 cycles after the last accept.
- **Masked early hit:** the core model asserts `core_hit` after shift 2 (window not full). Expect `match_cnt`=0 and `found`=0.
- **Illegal commands:** SCAN in IDLE → `err`=1 with no `core_shift`. LOAD in ARMED → `err`=1 with no `core_pat_we`. A following CLEAR → `err`=0, state IDLE, `core_clr` pulsed for 1 cycle, `cmd_ready` low during that cycle.
- **Saturation:** 300 consecutive hitting SCANs with CNT_W=8 → `match_cnt`=255 and held there; `first_pos` unchanged after the first hit.
- **CLEAR vs pending hit:** a SCAN accepted at edge N (its hit would be sampled at N+2) followed immediately by a CLEAR at N+1. Expect `match_cnt` to stay 0.
- **Reset and enable:** `ena`=0 with `cmd_valid`=1 → `cmd_ready`=0 and no strobes. Asserting `rst_n`=0 mid-scan → all outputs 0 asynchronously.
